// File: rtl/cpu_pkg.sv
// Shared predictor constants and the 2-bit saturating counter update rule.
package cpu_pkg;

   localparam int PRED_MODE_STATIC  = 0;
   localparam int PRED_MODE_BIMODAL = 1;
   localparam int PRED_MODE_GSHARE  = 2;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // Move one step towards the observed direction, clamping at SNT/ST.
   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      if (taken) begin
         return (cnt == ST) ? ST : cnt + 2'd1;
      end else begin
         return (cnt == SNT) ? SNT : cnt - 2'd1;
      end
   endfunction

endpackage

// File: rtl/pht_counter_array.sv
// Table of 2-bit direction counters: one combinational read, one synchronous write.
module pht_counter_array
   import cpu_pkg::*;
#(
   parameter int IDX = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [IDX-1:0] rd_idx,
   output logic           rd_taken,
   input  logic           wr_en,
   input  logic [IDX-1:0] wr_idx,
   input  logic           wr_taken
);

   localparam int DEPTH = 1 << IDX;

   logic [1:0] cnt_q [DEPTH];

   // Counters reset to weakly not-taken; a write nudges one counter towards the outcome.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            cnt_q[i] <= WNT;
         end
      end else if (wr_en) begin
         cnt_q[wr_idx] <= sat_update(cnt_q[wr_idx], wr_taken);
      end
   end

   // The counter MSB is the predicted direction.
   assign rd_taken = cnt_q[rd_idx][1];

endmodule

// File: rtl/next_pc_predictor.sv
// Next fetch PC predictor: tagged BTB plus PHT, static / bimodal / gshare direction.
module next_pc_predictor
   import cpu_pkg::*;
#(
   parameter  int XLEN        = 32,
   parameter  int BTB_ENTRIES = 16,
   parameter  int GHR_BITS    = 4,
   parameter  int MODE        = 1,
   localparam int IDX         = $clog2(BTB_ENTRIES)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] fetch_pc,
   output logic [XLEN-1:0] pred_next_pc,
   output logic            pred_taken,
   output logic [IDX-1:0]  pred_pht_idx,
   input  logic            resolve_valid,
   input  logic [XLEN-1:0] resolve_pc,
   input  logic            resolve_is_jump,
   input  logic            resolve_taken,
   input  logic [XLEN-1:0] resolve_target,
   input  logic [IDX-1:0]  resolve_pht_idx,
   input  logic            resolve_mispredict,
   output logic [31:0]     branch_cnt,
   output logic [31:0]     mispredict_cnt
);

   localparam int TAG_W = XLEN - IDX - 2;

   logic            btb_valid  [BTB_ENTRIES];
   logic [TAG_W-1:0] btb_tag   [BTB_ENTRIES];
   logic [XLEN-1:0] btb_target [BTB_ENTRIES];
   logic            btb_is_jump[BTB_ENTRIES];

   logic [GHR_BITS-1:0] ghr_q;
   logic [GHR_BITS-1:0] ghr_next;
   logic [IDX-1:0]      ghr_ext;
   logic [IDX-1:0]      fetch_idx;
   logic [TAG_W-1:0]    fetch_tag;
   logic [IDX-1:0]      res_idx;
   logic [TAG_W-1:0]    res_tag;
   logic                btb_hit;
   logic                pht_taken;
   logic                dir_taken;
   logic                btb_write;
   logic                pht_write;

   // Instructions are word aligned, so pc[1:0] never takes part in indexing or tags.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{fetch_pc[1:0], resolve_pc[1:0]};

   assign fetch_idx = fetch_pc[IDX+1:2];
   assign fetch_tag = fetch_pc[XLEN-1:IDX+2];
   assign res_idx   = resolve_pc[IDX+1:2];
   assign res_tag   = resolve_pc[XLEN-1:IDX+2];
   assign ghr_ext   = IDX'(ghr_q);
   assign ghr_next  = GHR_BITS'({ghr_q, resolve_taken});
   assign btb_write = resolve_valid && resolve_taken;
   assign pht_write = resolve_valid && !resolve_is_jump;

   // Zero-latency lookup; always sees the state before any same-cycle update.
   always_comb begin
      pred_pht_idx = fetch_idx;
      if (MODE == PRED_MODE_GSHARE) begin
         pred_pht_idx = fetch_idx ^ ghr_ext;
      end
      btb_hit      = btb_valid[fetch_idx] && (btb_tag[fetch_idx] == fetch_tag);
      dir_taken    = (MODE != PRED_MODE_STATIC) && pht_taken;
      pred_taken   = btb_hit && (btb_is_jump[fetch_idx] || dir_taken);
      pred_next_pc = pred_taken ? btb_target[fetch_idx] : fetch_pc + XLEN'(4);
   end

   pht_counter_array #(
      .IDX (IDX)
   ) u_pht (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (pred_pht_idx),
      .rd_taken (pht_taken),
      .wr_en    (pht_write),
      .wr_idx   (resolve_pht_idx),
      .wr_taken (resolve_taken)
   );

   // Valid bits: cleared on reset, set by any taken resolve (overwriting an alias).
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_valid[i] <= 1'b0;
         end
      end else if (btb_write) begin
         btb_valid[res_idx] <= 1'b1;
      end
   end

   // Entry payload needs no reset; it is qualified by the valid bit.
   always_ff @(posedge clk) begin
      if (!reset && btb_write) begin
         btb_tag[res_idx]     <= res_tag;
         btb_target[res_idx]  <= resolve_target;
         btb_is_jump[res_idx] <= resolve_is_jump;
      end
   end

   // Global history advances only on resolved conditional branches.
   always_ff @(posedge clk) begin
      if (reset) begin
         ghr_q <= '0;
      end else if (pht_write) begin
         ghr_q <= ghr_next;
      end
   end

   // Saturating resolve and mispredict statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
      end else if (resolve_valid) begin
         if (branch_cnt != '1) begin
            branch_cnt <= branch_cnt + 32'd1;
         end
         if (resolve_mispredict && (mispredict_cnt != '1)) begin
            mispredict_cnt <= mispredict_cnt + 32'd1;
         end
      end
   end

endmodule
